// File: rtl/phase_sequencer_pkg.sv
// Shared encodings, timing defaults and lamp decode for the phase sequencer.
// Optional forced phase change is enabled by defining MAX_GREEN_EN.
package phase_sequencer_pkg;

  localparam logic [1:0] ALLRED = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;

  localparam int MIN_GREEN_DEF = 5;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 1;
  localparam int MAX_GREEN_DEF = 20;

  localparam int TW = 5;
  localparam int EW = TW + 1;
  localparam logic [TW-1:0] TMAX = '1;

  typedef struct packed {
    logic [2:0] green;
    logic [2:0] yellow;
    logic [2:0] red;
  } lamps_t;

  function automatic logic onehot3(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

  function automatic lamps_t lamp_decode(
    input logic [1:0] s,
    input logic [2:0] ph
  );
    lamps_t l;
    l.green  = 3'b000;
    l.yellow = 3'b000;
    l.red    = 3'b111;
    unique case (1'b1)
      (s == GREEN): begin
        l.green = ph;
        l.red   = ~ph;
      end
      (s == YELLOW): begin
        l.yellow = ph;
        l.red    = ~ph;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_sequencer_timer.sv
// Saturating tick counter for the phase sequencer.
// Clear wins over tick so a state change always restarts at zero.
module phase_timer
  import phase_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          clr,
  output logic [TW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && (count != TMAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Three-state traffic phase FSM with registered lamp decode.
// Define MAX_GREEN_EN to force a change after MAX_GREEN green ticks.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int MIN_GREEN = MIN_GREEN_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF,
  parameter int MAX_GREEN = MAX_GREEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] req,
  input  logic [2:0] nsl_q,
  output logic [2:0] y,
  output logic [2:0] green,
  output logic [2:0] yellow,
  output logic [2:0] red,
  output logic       phase_load
);

  localparam logic [EW-1:0] ALLRED_N = EW'(ALLRED_T);
  localparam logic [EW-1:0] MIN_N    = EW'(MIN_GREEN);
  localparam logic [EW-1:0] YELLOW_N = EW'(YELLOW_T);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [2:0]    y_nxt;
  logic [TW-1:0] timer;
  logic [EW-1:0] elapsed;
  logic          req_ok;
  logic          swap;
  logic          forced;
  logic          load;
  lamps_t        lamps_nxt;

  // ticks seen including the one on this edge
  assign elapsed = {1'b0, timer} + EW'(1);
  assign req_ok  = onehot3(nsl_q);
  assign swap    = req_ok && (nsl_q != y);

`ifdef MAX_GREEN_EN
  localparam logic [EW-1:0] MAX_N = EW'(MAX_GREEN);
  assign forced = tick && (elapsed == MAX_N) && ((req & ~y) != 3'b000);
`else
  logic unused_cfg;
  assign unused_cfg = ^{req, TW'(MAX_GREEN)};
  assign forced     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    unique case (state)
      ALLRED: begin
        if (tick && (elapsed >= ALLRED_N) && req_ok) begin
          state_nxt = GREEN;
          y_nxt     = nsl_q;
        end
      end
      GREEN: begin
        if ((tick && (elapsed >= MIN_N) && swap) || forced) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (tick && (elapsed >= YELLOW_N)) begin
          state_nxt = ALLRED;
        end
      end
      default: state_nxt = ALLRED;
    endcase
  end

  assign load      = (state == ALLRED) && (state_nxt == GREEN);
  assign lamps_nxt = lamp_decode(state_nxt, y_nxt);

  phase_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .clr   (state_nxt != state),
    .count (timer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALLRED;
      y          <= 3'b000;
      green      <= 3'b000;
      yellow     <= 3'b000;
      red        <= 3'b111;
      phase_load <= 1'b0;
    end else begin
      state      <= state_nxt;
      y          <= y_nxt;
      green      <= lamps_nxt.green;
      yellow     <= lamps_nxt.yellow;
      red        <= lamps_nxt.red;
      phase_load <= load;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scenario bench for phase_sequencer with a cycle scoreboard.
// Forced-change expectations follow MAX_GREEN_EN.
module tb_phase_sequencer;

  localparam int MIN_GREEN = 5;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 1;
  localparam int MAX_GREEN = 20;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] yl;
    logic [2:0] r;
    logic [2:0] y;
    logic       pl;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [2:0] req;
  logic [2:0] nsl_q;
  logic [2:0] y;
  logic [2:0] green;
  logic [2:0] yellow;
  logic [2:0] red;
  logic       phase_load;

  int checks = 0;
  int errors = 0;

  obs_t sb[$];

  int         m_state;
  int         m_timer;
  logic [2:0] m_y;

  phase_sequencer #(
    .MIN_GREEN (MIN_GREEN),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .MAX_GREEN (MAX_GREEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .req        (req),
    .nsl_q      (nsl_q),
    .y          (y),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .phase_load (phase_load)
  );

  always #5 clk = ~clk;

  function automatic bit oh(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_timer = 0;
    m_y     = 3'b000;
  endtask

  // 0=ALLRED 1=GREEN 2=YELLOW
  task automatic model_step(output obs_t e);
    int         nxt;
    logic [2:0] ny;
    nxt = m_state;
    ny  = m_y;
    if (tick) begin
      if (m_state == 0) begin
        if (m_timer >= ALLRED_T - 1 && oh(nsl_q)) begin
          nxt = 1;
          ny  = nsl_q;
        end
      end else if (m_state == 1) begin
        if (m_timer >= MIN_GREEN - 1 && oh(nsl_q) && nsl_q != m_y)
          nxt = 2;
`ifdef MAX_GREEN_EN
        if (m_timer == MAX_GREEN - 1 && (req & ~m_y) != 3'b000)
          nxt = 2;
`endif
      end else begin
        if (m_timer >= YELLOW_T - 1) nxt = 0;
      end
    end
    e.pl = (m_state == 0 && nxt == 1);
    if (nxt != m_state) m_timer = 0;
    else if (tick && m_timer < 31) m_timer++;
    m_state = nxt;
    m_y     = ny;
    e.y  = ny;
    e.g  = (nxt == 1) ? ny : 3'b000;
    e.yl = (nxt == 2) ? ny : 3'b000;
    e.r  = (nxt == 0) ? 3'b111 : ~ny;
  endtask

  task automatic cycle(
    input logic       t,
    input logic [2:0] q,
    input logic [2:0] r
  );
    obs_t e;
    tick  = t;
    nsl_q = q;
    req   = r;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin : monitor
    obs_t e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({green, yellow, red, y, phase_load} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got g=%b yl=%b r=%b y=%b pl=%b exp g=%b yl=%b r=%b y=%b pl=%b",
                 $time, green, yellow, red, y, phase_load,
                 e.g, e.yl, e.r, e.y, e.pl);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ($countones({green[i], yellow[i], red[i]}) != 1) begin
        errors++;
        $display("FAIL one_lamp dir=%0d t=%0t got g=%b yl=%b r=%b exp exactly one",
                 i, $time, green[i], yellow[i], red[i]);
      end
    end
    checks++;
    if ($countones(green) > 1) begin
      errors++;
      $display("FAIL green_conflict t=%0t got %b exp at most one", $time, green);
    end
  end

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({red, green, yellow, y, phase_load} !== {3'b111, 9'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got r=%b g=%b yl=%b y=%b pl=%b exp r=111 rest 0",
               red, green, yellow, y, phase_load);
    end
    @(posedge clk);
    #2;
    tick = 1'b1;
    nsl_q = 3'b001;
    @(posedge clk);
    #2;
    checks++;
    if ({red, green, y} !== {3'b111, 6'b0}) begin
      errors++;
      $display("FAIL reset_hold got r=%b g=%b y=%b exp r=111 g=000 y=000",
               red, green, y);
    end
    tick  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_first_load();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b001, 3'b000);
      checks++;
      if ({red, y} !== {3'b111, 3'b000}) begin
        errors++;
        $display("FAIL first_wait got r=%b y=%b exp r=111 y=000", red, y);
      end
    end
    cycle(1'b1, 3'b001, 3'b000);
    checks++;
    if ({y, green, red, phase_load} !== {3'b001, 3'b001, 3'b110, 1'b1}) begin
      errors++;
      $display("FAIL first_load got y=%b g=%b r=%b pl=%b exp y=001 g=001 r=110 pl=1",
               y, green, red, phase_load);
    end
    cycle(1'b0, 3'b001, 3'b000);
    checks++;
    if ({phase_load, y} !== {1'b0, 3'b001}) begin
      errors++;
      $display("FAIL first_pulse got pl=%b y=%b exp pl=0 y=001", phase_load, y);
    end
  endtask

  task automatic test_phase_change();
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 3'b010, 3'b000);
      cycle(1'b0, 3'b010, 3'b000);
      cycle(1'b1, 3'b010, 3'b000);
      checks++;
      if (k < 5 && green !== 3'b001) begin
        errors++;
        $display("FAIL min_green k=%0d got g=%b exp 001", k, green);
      end else if (k == 5 && {yellow, green} !== {3'b001, 3'b000}) begin
        errors++;
        $display("FAIL to_yellow got yl=%b g=%b exp yl=001 g=000", yellow, green);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 3'b010, 3'b000);
      cycle(1'b1, 3'b010, 3'b000);
      checks++;
      if (k < 3 && yellow !== 3'b001) begin
        errors++;
        $display("FAIL yellow_hold k=%0d got yl=%b exp 001", k, yellow);
      end else if (k == 3 && {red, y} !== {3'b111, 3'b001}) begin
        errors++;
        $display("FAIL to_allred got r=%b y=%b exp r=111 y=001", red, y);
      end
    end
    cycle(1'b0, 3'b010, 3'b000);
    cycle(1'b1, 3'b010, 3'b000);
    checks++;
    if ({y, green, phase_load} !== {3'b010, 3'b010, 1'b1}) begin
      errors++;
      $display("FAIL second_load got y=%b g=%b pl=%b exp y=010 g=010 pl=1",
               y, green, phase_load);
    end
  endtask

  task automatic test_bad_request();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 3'b100, 3'b000);
      cycle(1'b1, (i % 2) ? 3'b011 : 3'b000, 3'b000);
      checks++;
      if ({green, y} !== {3'b010, 3'b010}) begin
        errors++;
        $display("FAIL bad_req i=%0d got g=%b y=%b exp g=010 y=010", i, green, y);
      end
    end
  endtask

  task automatic test_tick_held();
    cycle(1'b1, 3'b100, 3'b000);
    checks++;
    if (yellow !== 3'b010) begin
      errors++;
      $display("FAIL held_yellow got yl=%b exp 010", yellow);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'b100, 3'b000);
    checks++;
    if ({green, y} !== {3'b100, 3'b100}) begin
      errors++;
      $display("FAIL held_green got g=%b y=%b exp g=100 y=100", green, y);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b100, 3'b000);
    checks++;
    if (green !== 3'b100) begin
      errors++;
      $display("FAIL held_stay got g=%b exp 100", green);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10 && m_state != 2; i++)
      cycle(1'b1, 3'b001, 3'b000);
    checks++;
    if (yellow !== 3'b100) begin
      errors++;
      $display("FAIL pre_reset_yellow got yl=%b exp 100", yellow);
    end
    cycle(1'b0, 3'b001, 3'b000);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({red, green, yellow, y, phase_load} !== {3'b111, 9'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got r=%b g=%b yl=%b y=%b pl=%b exp r=111 rest 0",
               red, green, yellow, y, phase_load);
    end
    sb.delete();
    model_reset();
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_max_green();
    cycle(1'b0, 3'b100, 3'b001);
    cycle(1'b0, 3'b100, 3'b001);
    checks++;
    if ({red, y} !== {3'b111, 3'b000}) begin
      errors++;
      $display("FAIL post_reset_wait got r=%b y=%b exp r=111 y=000", red, y);
    end
    cycle(1'b1, 3'b100, 3'b001);
    checks++;
    if ({y, phase_load} !== {3'b100, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_load got y=%b pl=%b exp y=100 pl=1", y, phase_load);
    end
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1, 3'b100, 3'b001);
`ifdef MAX_GREEN_EN
      if (k == 19) begin
        checks++;
        if (green !== 3'b100) begin
          errors++;
          $display("FAIL max_pre got g=%b exp 100", green);
        end
      end
      if (k == 20) begin
        checks++;
        if ({yellow, green} !== {3'b100, 3'b000}) begin
          errors++;
          $display("FAIL max_force got yl=%b g=%b exp yl=100 g=000", yellow, green);
        end
        break;
      end
`else
      if (k == 40) begin
        checks++;
        if ({green, y} !== {3'b100, 3'b100}) begin
          errors++;
          $display("FAIL no_force got g=%b y=%b exp g=100 y=100", green, y);
        end
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b1;
    tick  = 1'b0;
    req   = 3'b000;
    nsl_q = 3'b000;
    model_reset();
    test_reset();
    test_first_load();
    test_phase_change();
    test_bad_request();
    test_tick_held();
    test_async_reset();
    test_max_green();
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MIN_GREEN, 5, ticks of green before a phase change is allowed.
- YELLOW_T, 3, ticks of yellow.
- ALLRED_T, 1, ticks of all-red clearance.
- MAX_GREEN, 20, green ticks before a forced change (MAX_GREEN_EN only).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle timebase enable, nominally 1 Hz.
- req  input  3  per-direction vehicle requests; the same vector drives the next-state logic z input.
- nsl_q  input  3  next phase {Q2,Q1,Q0} from the next-state logic.
- y  output  3  registered current phase, fed back to the next-state logic y2..y0.
- green  output  3  per-direction green lamps.
- yellow  output  3  per-direction yellow lamps.
- red  output  3  per-direction red lamps.
- phase_load  output  1  one-cycle pulse on the cycle y is loaded.

Function
REQ-003 FSM SHALL have exactly three states: ALLRED, GREEN, YELLOW.
REQ-004 Internal 5-bit timer SHALL increment on tick, saturate at 31, and clear to 0 on every state change.
REQ-005 "After N ticks" SHALL mean: transition at the clock edge where tick=1 and timer==N-1.
REQ-006 ALLRED SHALL, after ALLRED_T ticks, move to GREEN and load y<=nsl_q only if nsl_q is nonzero one-hot.
- Otherwise stay in ALLRED with timer saturating and y unchanged.
REQ-007 GREEN SHALL, after MIN_GREEN ticks (timer>=MIN_GREEN-1 with tick=1), move to YELLOW when nsl_q is nonzero one-hot and differs from y.
- Otherwise stay in GREEN.
REQ-008 YELLOW SHALL move to ALLRED after YELLOW_T ticks, unconditionally.
REQ-009 y SHALL change only on the ALLRED->GREEN edge; it holds the last served phase through YELLOW and ALLRED.
REQ-010 phase_load SHALL be 1 for exactly the cycle after the ALLRED->GREEN edge, and 0 otherwise.
REQ-011 Lamp outputs SHALL be registered and follow the state:
- GREEN: green=y, red=~y, yellow=0.
- YELLOW: yellow=y, red=~y, green=0.
- ALLRED: red=3'b111, green=yellow=0.
REQ-012 Each direction SHALL have exactly one lamp lit in every cycle.
REQ-013 Non-one-hot nsl_q (000, 011, 111, etc.) SHALL be ignored as a change request in every state.
REQ-014 Changes on nsl_q or req between ticks SHALL NOT affect the state; only the values sampled on a tick cycle matter.
REQ-015 tick held high SHALL advance the timer every cycle with no other behaviour change.

Reset
REQ-016 rst_n low SHALL asynchronously force ALLRED, timer=0, y=3'b000, red=3'b111, green=yellow=0, phase_load=0.
REQ-017 Reset asserted mid-GREEN or mid-YELLOW SHALL abort immediately to all-red with no yellow interval.
REQ-018 After reset release, the first phase SHALL be loaded only after a full ALLRED_T interval.

Configuration
REQ-019 With macro MAX_GREEN_EN defined: in GREEN, when tick=1, timer==MAX_GREEN-1, and (req & ~y)!=0, the FSM SHALL move to YELLOW regardless of nsl_q.
REQ-020 Without MAX_GREEN_EN: no forced change; the MAX_GREEN parameter SHALL be present but unused.

Structure
REQ-021 State encodings (ALLRED=2'd0, GREEN=2'd1, YELLOW=2'd2) and timing defaults SHALL live in the shared traffic package/include.
REQ-022 The timer SHALL be a sub-module, phase_timer (tick, clr, 5-bit saturating count); the FSM and lamp decode SHALL stay in phase_sequencer.

Verification
REQ-023 Reset, then nsl_q=3'b001 held, ALLRED_T=1: one tick -> y=001, green=001, red=110, phase_load pulses once.
REQ-024 In GREEN y=001, nsl_q=010 from the first tick: no change for 4 ticks; YELLOW after tick 5 (yellow=001); ALLRED after 3 more ticks; GREEN y=010 after 1 more tick.
REQ-025 In GREEN, nsl_q=3'b011 or 3'b000 for 30 ticks -> stays GREEN, y unchanged.
REQ-026 rst_n pulsed low during YELLOW, between clock edges -> outputs immediately become red=111, y=000, with no clock edge needed.
REQ-027 MAX_GREEN_EN defined, y=100, nsl_q=100, req=001: YELLOW entered on tick 20. Same test without the macro: GREEN held indefinitely.
REQ-028 Every test SHALL check each cycle that every direction has exactly one lamp lit and that green is never set on two directions.
